// File: rtl/pb1_oci_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pb1_oci_pkg
//  Description : Shared constants, state encoding and slot helper for the
//                OCI trace scheduler (DCT capture buffer geometry, source
//                tags, scheduler FSM states).
//  Revision    : 1.0 - initial release
// ============================================================================
package pb1_oci_pkg;

    // DCT capture buffer geometry: three 10-bit slots packed into 30 bits.
    localparam int DCT_SLOTS = 3;
    localparam int ATOM_W    = 9;
    localparam int SLOT_W    = 10;
    localparam int FRAME_W   = 36;

    // Source tag stored in slot bit 9; also used as the arbiter pointer value.
    localparam logic TAG_ITR = 1'b0;
    localparam logic TAG_DTR = 1'b1;

    // Scheduler state encoding.
    typedef logic [1:0] oci_state_t;
    localparam oci_state_t FILL = 2'd0;
    localparam oci_state_t EMIT = 2'd1;
    localparam oci_state_t DONE = 2'd2;

    // Build one buffer slot: {source tag, atom payload}.
    function automatic logic [SLOT_W-1:0] make_slot(input logic tag,
                                                    input logic [ATOM_W-1:0] atom);
        return {tag, atom};
    endfunction

endpackage
`default_nettype wire

// File: rtl/pb1_oci_rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : pb1_oci_rr_arb2
//  Description : Two-requester round-robin arbiter with a registered pointer.
//                A lone requester always wins. Under contention the pointer's
//                owner wins and the pointer moves to the other requester.
//                With no grant the pointer holds.
//  Ports       : clk, reset_n      - clock, async active-low reset
//                i_en              - grants allowed this cycle
//                i_req_itr/i_req_dtr - requests
//                o_gnt_itr/o_gnt_dtr - one-hot (or zero) grants, combinational
//  Revision    : 1.0 - initial release
// ============================================================================
module pb1_oci_rr_arb2
    import pb1_oci_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic i_en,
    input  logic i_req_itr,
    input  logic i_req_dtr,
    output logic o_gnt_itr,
    output logic o_gnt_dtr
);

    logic r_ptr;
    logic w_both;

    assign w_both    = i_req_itr & i_req_dtr;
    assign o_gnt_itr = i_en & i_req_itr & (~i_req_dtr | (r_ptr == TAG_ITR));
    assign o_gnt_dtr = i_en & i_req_dtr & (~i_req_itr | (r_ptr == TAG_DTR));

    // Pointer only rotates when a contended grant is actually issued.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr <= TAG_ITR;
        end else if (i_en && w_both) begin
            r_ptr <= ~r_ptr;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pb1_oci_trace_sched.sv
`default_nettype none
// ============================================================================
//  Module      : pb1_oci_trace_sched
//  Description : Packs instruction/data trace atoms into the 3-slot DCT
//                capture buffer, emits full or timed-out partial frames to the
//                trace RAM writer over valid/ready, and sequences the
//                end-of-test flush.
//  Ports       : clk, reset_n               - clock, async active-low reset
//                itr_atom/valid/ready       - instruction trace source
//                dtr_atom/valid/ready       - data trace source
//                test_ending                - level request: flush and stop
//                frame_data/valid/ready     - frame output to trace RAM writer
//                dct_buffer, dct_count      - packing buffer observation
//                test_has_ended             - flush complete, block halted
//                frame_cnt                  - frames emitted (wrapping)
//  Revision    : 1.0 - initial release
// ============================================================================
module pb1_oci_trace_sched
    import pb1_oci_pkg::*;
#(
    parameter int FLUSH_TIMEOUT = 16,
    parameter int CNT_W         = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [ATOM_W-1:0]    itr_atom,
    input  logic                 itr_valid,
    output logic                 itr_ready,
    input  logic [ATOM_W-1:0]    dtr_atom,
    input  logic                 dtr_valid,
    output logic                 dtr_ready,
    input  logic                 test_ending,
    output logic [FRAME_W-1:0]   frame_data,
    output logic                 frame_valid,
    input  logic                 frame_ready,
    output logic [DCT_SLOTS*SLOT_W-1:0] dct_buffer,
    output logic [3:0]           dct_count,
    output logic                 test_has_ended,
    output logic [CNT_W-1:0]     frame_cnt
);

    localparam int c_IDLE_W = (FLUSH_TIMEOUT < 2) ? 1 : $clog2(FLUSH_TIMEOUT + 1);
    localparam logic [c_IDLE_W-1:0] c_IDLE_LAST = c_IDLE_W'(FLUSH_TIMEOUT - 1);
    localparam logic [c_IDLE_W-1:0] c_IDLE_ONE  = c_IDLE_W'(1);
    localparam logic [CNT_W-1:0]    c_CNT_ONE   = CNT_W'(1);
    localparam logic [3:0]          c_FULL      = 4'(DCT_SLOTS);

    oci_state_t                    r_state;
    logic [3:0]                    r_count;
    logic [DCT_SLOTS*SLOT_W-1:0]   r_buf;
    logic [c_IDLE_W-1:0]           r_idle;
    logic                          r_end_req;
    logic [CNT_W-1:0]              r_frame_cnt;

    logic                          w_arb_en;
    logic                          w_gnt_itr;
    logic                          w_gnt_dtr;
    logic                          w_accept;
    logic [SLOT_W-1:0]             w_slot;
    logic [3:0]                    w_count_acc;
    logic                          w_timeout;

    // reset_n gates the enable so the ready outputs drop the moment reset is
    // asserted, not only after the state register has been cleared.
    assign w_arb_en = reset_n & (r_state == FILL) & (r_count < c_FULL);

    pb1_oci_rr_arb2 u_arb (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_en      (w_arb_en),
        .i_req_itr (itr_valid),
        .i_req_dtr (dtr_valid),
        .o_gnt_itr (w_gnt_itr),
        .o_gnt_dtr (w_gnt_dtr)
    );

    assign w_accept    = w_gnt_itr | w_gnt_dtr;
    assign w_slot      = w_gnt_dtr ? make_slot(TAG_DTR, dtr_atom)
                                   : make_slot(TAG_ITR, itr_atom);
    assign w_count_acc = r_count + {3'b000, w_accept};

    // Fires on the idle cycle that brings the counter up to FLUSH_TIMEOUT.
    assign w_timeout = (FLUSH_TIMEOUT != 0) && !w_accept && (r_count != 4'd0)
                       && (r_idle == c_IDLE_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= FILL;
            r_count     <= '0;
            r_buf       <= '0;
            r_idle      <= '0;
            r_end_req   <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            case (r_state)
                FILL: begin
                    if (w_accept) begin
                        case (r_count[1:0])
                            2'd0:    r_buf[SLOT_W-1:0]          <= w_slot;
                            2'd1:    r_buf[2*SLOT_W-1:SLOT_W]   <= w_slot;
                            2'd2:    r_buf[3*SLOT_W-1:2*SLOT_W] <= w_slot;
                            default: ;
                        endcase
                    end
                    r_count <= w_count_acc;
                    if (w_accept || (r_count == 4'd0)) begin
                        r_idle <= '0;
                    end else begin
                        r_idle <= r_idle + c_IDLE_ONE;
                    end
                    // An end request flushes whatever is buffered, including
                    // an atom accepted on the same edge.
                    if (test_ending) begin
                        if (w_count_acc != 4'd0) begin
                            r_state   <= EMIT;
                            r_end_req <= 1'b1;
                        end else begin
                            r_state <= DONE;
                        end
                    end else if ((w_count_acc == c_FULL) || w_timeout) begin
                        r_state <= EMIT;
                    end
                end
                EMIT: begin
                    if (test_ending) begin
                        r_end_req <= 1'b1;
                    end
                    if (frame_ready) begin
                        r_buf       <= '0;
                        r_count     <= '0;
                        r_idle      <= '0;
                        r_frame_cnt <= r_frame_cnt + c_CNT_ONE;
                        r_state     <= (r_end_req || test_ending) ? DONE : FILL;
                    end
                end
                DONE: ;
                default: r_state <= FILL;
            endcase
        end
    end

    assign itr_ready      = w_gnt_itr;
    assign dtr_ready      = w_gnt_dtr;
    assign frame_valid    = (r_state == EMIT);
    assign test_has_ended = (r_state == DONE);
    assign dct_buffer     = r_buf;
    assign dct_count      = r_count;
    assign frame_data     = {r_count, 2'b00, r_buf};
    assign frame_cnt      = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pb1_oci_trace_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pb1_oci_trace_sched
//  Description : Self-checking bench for pb1_oci_trace_sched. Expected frames
//                are queued as atoms are driven and compared when the DUT
//                completes a frame handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pb1_oci_trace_sched;

    logic        clk;
    logic        reset_n;
    logic [8:0]  itr_atom;
    logic        itr_valid;
    logic        itr_ready;
    logic [8:0]  dtr_atom;
    logic        dtr_valid;
    logic        dtr_ready;
    logic        test_ending;
    logic [35:0] frame_data;
    logic        frame_valid;
    logic        frame_ready;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        test_has_ended;
    logic [15:0] frame_cnt;

    int          n_checks;
    int          n_errors;
    logic [35:0] sb_q[$];
    logic        ptr_m;

    pb1_oci_trace_sched #(
        .FLUSH_TIMEOUT (16),
        .CNT_W         (16)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .itr_atom       (itr_atom),
        .itr_valid      (itr_valid),
        .itr_ready      (itr_ready),
        .dtr_atom       (dtr_atom),
        .dtr_valid      (dtr_valid),
        .dtr_ready      (dtr_ready),
        .test_ending    (test_ending),
        .frame_data     (frame_data),
        .frame_valid    (frame_valid),
        .frame_ready    (frame_ready),
        .dct_buffer     (dct_buffer),
        .dct_count      (dct_count),
        .test_has_ended (test_has_ended),
        .frame_cnt      (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [35:0] pack(input logic [3:0] cnt, input logic [9:0] s0,
                                         input logic [9:0] s1, input logic [9:0] s2);
        return {cnt, 2'b00, s2, s1, s0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Contended packing of three atoms: itr=0x0AA, dtr=0x155, order set by ptr_m.
    task automatic pack_both(input string tag);
        logic [9:0] s [3];
        logic       exp_itr;
        for (int i = 0; i < 3; i++) begin
            itr_valid = 1'b1; itr_atom = 9'h0AA;
            dtr_valid = 1'b1; dtr_atom = 9'h155;
            exp_itr = (ptr_m == 1'b0);
            s[i] = exp_itr ? {1'b0, 9'h0AA} : {1'b1, 9'h155};
            @(negedge clk);
            chk_eq({tag, "_itr_rdy"}, itr_ready, exp_itr);
            chk_eq({tag, "_dtr_rdy"}, dtr_ready, !exp_itr);
            ptr_m = ~ptr_m;
            tick();
        end
        sb_q.push_back(pack(4'd3, s[0], s[1], s[2]));
        itr_valid = 1'b0;
        dtr_valid = 1'b0;
    endtask

    // Scoreboard: every completed frame handshake pops one expected frame.
    always @(negedge clk) begin
        if (reset_n && frame_valid && frame_ready) begin
            if (sb_q.size() == 0) begin
                chk_eq("sb_unexpected_frame", frame_data, 36'h0);
            end else begin
                chk_eq("sb_frame", frame_data, sb_q.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog_timeout obs=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        logic ok;
        n_checks = 0;
        n_errors = 0;
        ptr_m    = 1'b0;
        reset_n  = 1'b0;
        itr_atom = '0; itr_valid = 1'b0;
        dtr_atom = '0; dtr_valid = 1'b0;
        test_ending = 1'b0;
        frame_ready = 1'b0;

        // ---- reset state
        #12;
        chk_eq("rst_frame_valid", frame_valid, 1'b0);
        chk_eq("rst_frame_data", frame_data, 36'h0);
        chk_eq("rst_count", dct_count, 4'd0);
        chk_eq("rst_ended", test_has_ended, 1'b0);
        chk_eq("rst_frame_cnt", frame_cnt, 16'd0);
        reset_n = 1'b1;
        tick();

        // ---- single itr source fills a frame
        frame_ready = 1'b1;
        sb_q.push_back(pack(4'd3, 10'h001, 10'h002, 10'h003));
        for (int i = 0; i < 3; i++) begin
            itr_valid = 1'b1;
            itr_atom  = 9'(i + 1);
            @(negedge clk);
            chk_eq("s1_itr_rdy", itr_ready, 1'b1);
            chk_eq("s1_dtr_rdy", dtr_ready, 1'b0);
            tick();
        end
        itr_valid = 1'b0;
        @(negedge clk);
        chk_eq("s1_frame_valid", frame_valid, 1'b1);
        chk_eq("s1_count", dct_count, 4'd3);
        chk_eq("s1_frame_data", frame_data, 36'h3_0030_0801);
        tick();
        @(negedge clk);
        chk_eq("s1_fv_after", frame_valid, 1'b0);
        chk_eq("s1_frame_cnt", frame_cnt, 16'd1);
        chk_eq("s1_count_clr", dct_count, 4'd0);
        tick();

        // ---- both sources contend: itr, dtr, itr
        pack_both("s2");
        @(negedge clk);
        chk_eq("s2_frame_valid", frame_valid, 1'b1);
        chk_eq("s2_frame_data", frame_data,
               pack(4'd3, 10'h0AA, 10'h355, 10'h0AA));
        tick();
        @(negedge clk);
        chk_eq("s2_frame_cnt", frame_cnt, 16'd2);
        tick();

        // ---- one dtr atom, idle timeout, then back-pressure
        frame_ready = 1'b0;
        dtr_valid = 1'b1;
        dtr_atom  = 9'h1FF;
        @(negedge clk);
        chk_eq("s3_dtr_rdy", dtr_ready, 1'b1);
        sb_q.push_back(pack(4'd1, 10'h3FF, 10'h000, 10'h000));
        tick();
        dtr_valid = 1'b0;
        n = 0;
        while (!frame_valid && n < 40) begin
            tick();
            n++;
        end
        chk_eq("s3_timeout_cycles", n, 16);
        itr_valid = 1'b1; itr_atom = 9'h077;
        dtr_valid = 1'b1; dtr_atom = 9'h066;
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!(frame_valid && frame_data == 36'h1_0000_03FF && !itr_ready && !dtr_ready))
                ok = 1'b0;
            tick();
        end
        chk_eq("s3_stall_hold", ok, 1'b1);
        itr_valid = 1'b0;
        dtr_valid = 1'b0;
        frame_ready = 1'b1;
        tick();
        @(negedge clk);
        chk_eq("s3_fv_after", frame_valid, 1'b0);
        chk_eq("s3_count_clr", dct_count, 4'd0);
        chk_eq("s3_frame_cnt", frame_cnt, 16'd3);
        chk_eq("s3_not_ended", test_has_ended, 1'b0);
        tick();

        // ---- two atoms, then end-of-test flush
        frame_ready = 1'b0;
        itr_valid = 1'b1; itr_atom = 9'h011;
        @(negedge clk);
        chk_eq("s4_rdy0", itr_ready, 1'b1);
        tick();
        itr_atom = 9'h022;
        @(negedge clk);
        chk_eq("s4_rdy1", itr_ready, 1'b1);
        sb_q.push_back(pack(4'd2, 10'h011, 10'h022, 10'h000));
        tick();
        itr_valid = 1'b0;
        test_ending = 1'b1;
        tick();
        test_ending = 1'b0;
        @(negedge clk);
        chk_eq("s4_frame_valid", frame_valid, 1'b1);
        chk_eq("s4_count", dct_count, 4'd2);
        tick();
        frame_ready = 1'b1;
        tick();
        itr_valid = 1'b1; dtr_valid = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (!(test_has_ended && !frame_valid && !itr_ready && !dtr_ready))
                ok = 1'b0;
            tick();
        end
        chk_eq("s4_done_hold", ok, 1'b1);
        chk_eq("s4_ended", test_has_ended, 1'b1);
        chk_eq("s4_frame_cnt", frame_cnt, 16'd4);
        itr_valid = 1'b0; dtr_valid = 1'b0;

        // ---- reset in EMIT discards the frame
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        ptr_m = 1'b0;
        tick();
        frame_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            itr_valid = 1'b1;
            itr_atom  = 9'(9'h101 + i);
            tick();
        end
        itr_valid = 1'b0;
        @(negedge clk);
        chk_eq("s5_emit", frame_valid, 1'b1);
        #2;
        reset_n = 1'b0;
        itr_valid = 1'b1; dtr_valid = 1'b1;
        #1;
        chk_eq("s5_rst_fv", frame_valid, 1'b0);
        chk_eq("s5_rst_data", frame_data, 36'h0);
        chk_eq("s5_rst_buf", dct_buffer, 30'h0);
        chk_eq("s5_rst_rdy", {itr_ready, dtr_ready}, 2'b00);
        chk_eq("s5_rst_cnt", frame_cnt, 16'd0);
        itr_valid = 1'b0; dtr_valid = 1'b0;
        #1;
        reset_n = 1'b1;
        tick();
        frame_ready = 1'b1;
        pack_both("s5");
        @(negedge clk);
        chk_eq("s5_frame_valid", frame_valid, 1'b1);
        tick();
        @(negedge clk);
        chk_eq("s5_frame_cnt", frame_cnt, 16'd1);
        tick();
        tick();

        chk_eq("sb_empty", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
